// File: rtl/vm_pkg.sv
// Shared vending-machine types: money width, coin denominations and dispenser states.
package vm_pkg;

    localparam int MONEY_W   = 6;
    localparam int NUM_DENOM = 4;

    localparam logic [MONEY_W-1:0] COIN_50 = 6'd50;
    localparam logic [MONEY_W-1:0] COIN_10 = 6'd10;
    localparam logic [MONEY_W-1:0] COIN_5  = 6'd5;
    localparam logic [MONEY_W-1:0] COIN_1  = 6'd1;

    // Index order matches the inv_empty bit order {50,10,5,1}.
    typedef enum logic [1:0] {
        DENOM_1  = 2'd0,
        DENOM_5  = 2'd1,
        DENOM_10 = 2'd2,
        DENOM_50 = 2'd3
    } denom_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } disp_state_e;

endpackage

// File: rtl/coin_selector.sv
// Greedy coin pick: largest denomination that fits the remaining amount and is in stock.
module coin_selector
    import vm_pkg::*;
(
    input  logic [MONEY_W-1:0]   remaining_i,
    input  logic [NUM_DENOM-1:0] avail_i,
    output logic                 found_o,
    output denom_e               index_o,
    output logic [MONEY_W-1:0]   value_o
);

    always_comb begin
        // NOTE: every output gets a default before the if-chain, so no path can infer a latch.
        found_o = 1'b0;
        index_o = DENOM_1;
        value_o = '0;
        if (avail_i[DENOM_50] && remaining_i >= COIN_50) begin
            found_o = 1'b1;
            index_o = DENOM_50;
            value_o = COIN_50;
        end else if (avail_i[DENOM_10] && remaining_i >= COIN_10) begin
            found_o = 1'b1;
            index_o = DENOM_10;
            value_o = COIN_10;
        end else if (avail_i[DENOM_5] && remaining_i >= COIN_5) begin
            found_o = 1'b1;
            index_o = DENOM_5;
            value_o = COIN_5;
        end else if (avail_i[DENOM_1] && remaining_i >= COIN_1) begin
            found_o = 1'b1;
            index_o = DENOM_1;
            value_o = COIN_1;
        end
    end

endmodule

// File: rtl/coin_change_dispenser.sv
// Change dispenser: accepts one amount, ejects coins greedily from a limited inventory,
// reports any unpaid remainder and aborts a coin whose eject ack never arrives.
module coin_change_dispenser
    import vm_pkg::*;
#(
    parameter int INV_INIT    = 4,
    parameter int INV_MAX     = 15,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [MONEY_W-1:0]   req_amount,
    output logic                 req_ready,
    input  logic                 refill,
    output logic                 coin_valid,
    output logic [MONEY_W-1:0]   coin_value,
    input  logic                 coin_ack,
    output logic                 done,
    output logic [MONEY_W-1:0]   short_amount,
    output logic                 fault,
    output logic [NUM_DENOM-1:0] inv_empty
);

    localparam int INV_W = $clog2(INV_MAX + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [INV_W-1:0] INV_INIT_V = INV_W'(INV_INIT);
    localparam logic [INV_W-1:0] INV_MAX_V  = INV_W'(INV_MAX);
    localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(ACK_TIMEOUT);

    disp_state_e          state_q, state_d;
    logic [MONEY_W-1:0]   remaining_q, remaining_d;
    logic [MONEY_W-1:0]   coin_value_q, coin_value_d;
    logic [MONEY_W-1:0]   short_q, short_d;
    denom_e               idx_q, idx_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 fault_q, fault_d;
    logic [INV_W-1:0]     inv_q [NUM_DENOM];
    logic [INV_W-1:0]     inv_d [NUM_DENOM];

    logic [NUM_DENOM-1:0] avail;
    logic                 sel_found;
    denom_e               sel_index;
    logic [MONEY_W-1:0]   sel_value;

    always_comb begin
        for (int i = 0; i < NUM_DENOM; i++) begin
            avail[i] = (inv_q[i] != '0);
        end
    end

    coin_selector u_selector (
        .remaining_i (remaining_q),
        .avail_i     (avail),
        .found_o     (sel_found),
        .index_o     (sel_index),
        .value_o     (sel_value)
    );

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        coin_value_d = coin_value_q;
        short_d      = short_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        fault_d      = 1'b0;
        inv_d        = inv_q;

        case (state_q)
            IDLE: begin
                // Refill lands before the accept so a simultaneous request sees full stock.
                if (refill) begin
                    for (int i = 0; i < NUM_DENOM; i++) begin
                        inv_d[i] = INV_MAX_V;
                    end
                end
                if (req_valid) begin
                    remaining_d = req_amount;
                    short_d     = '0;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                if (sel_found) begin
                    coin_value_d = sel_value;
                    idx_d        = sel_index;
                    tmo_d        = '0;
                    state_d      = ISSUE;
                end else begin
                    short_d = remaining_q;
                    state_d = DONE;
                end
            end
            ISSUE: begin
                // Ack is checked first so an ack on the timeout edge still pays the coin.
                if (coin_ack) begin
                    remaining_d = remaining_q - coin_value_q;
                    if (inv_q[idx_q] != '0) begin
                        inv_d[idx_q] = inv_q[idx_q] - 1'b1;
                    end
                    state_d = SELECT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TMO_LIMIT) begin
                        short_d = remaining_q;
                        fault_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            coin_value_q <= '0;
            short_q      <= '0;
            idx_q        <= DENOM_1;
            tmo_q        <= '0;
            fault_q      <= 1'b0;
            // NOTE: the inventory array is reset explicitly; it holds architectural state
            // (coin counts), so it must never power up to arbitrary contents.
            for (int i = 0; i < NUM_DENOM; i++) begin
                inv_q[i] <= INV_INIT_V;
            end
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            coin_value_q <= coin_value_d;
            short_q      <= short_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            fault_q      <= fault_d;
            for (int i = 0; i < NUM_DENOM; i++) begin
                inv_q[i] <= inv_d[i];
            end
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign coin_valid   = (state_q == ISSUE);
    assign done         = (state_q == DONE);
    assign coin_value   = coin_value_q;
    assign short_amount = short_q;
    assign fault        = fault_q;
    assign inv_empty    = ~avail;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser: expected coins and results are queued per request
// and compared as the dispenser ejects coins and signals done.
module tb_coin_change_dispenser;
    import vm_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic [MONEY_W-1:0]   req_amount;
    logic                 req_ready;
    logic                 refill;
    logic                 coin_valid;
    logic [MONEY_W-1:0]   coin_value;
    logic                 coin_ack;
    logic                 done;
    logic [MONEY_W-1:0]   short_amount;
    logic                 fault;
    logic [NUM_DENOM-1:0] inv_empty;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_coin_q[$];
    int exp_short_q[$];
    int exp_fault_q[$];

    always #5 clk = ~clk;

    coin_change_dispenser #(
        .INV_INIT    (4),
        .INV_MAX     (15),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_amount   (req_amount),
        .req_ready    (req_ready),
        .refill       (refill),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .coin_ack     (coin_ack),
        .done         (done),
        .short_amount (short_amount),
        .fault        (fault),
        .inv_empty    (inv_empty)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_result(input int short_amt, input int flt);
        exp_short_q.push_back(short_amt);
        exp_fault_q.push_back(flt);
    endtask

    task automatic clear_scoreboard();
        exp_coin_q.delete();
        exp_short_q.delete();
        exp_fault_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        refill = 1'b0;
        coin_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_scoreboard();
    endtask

    // Called at a negedge; waits (bounded) for req_ready, then presents the request.
    task automatic send_req(input logic [MONEY_W-1:0] amt, input string tag);
        int w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, " req_ready"}, req_ready, 1);
        req_amount = amt;
        req_valid  = 1'b1;
    endtask

    // Runs one request to completion; cycle 1 is the first negedge after the accept edge.
    // With ack_en, coin_ack is returned the cycle after coin_valid rises.
    task automatic serve(input string tag, input bit ack_en, output int done_cyc, output int valid_cyc);
        int seen = 0;
        int cur  = 0;
        bit fin  = 1'b0;
        int es, ef;
        done_cyc  = 0;
        valid_cyc = 0;
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            coin_ack  = 1'b0;
            if (done) begin
                fin      = 1'b1;
                done_cyc = cyc;
                es = (exp_short_q.size() > 0) ? exp_short_q.pop_front() : -1;
                ef = (exp_fault_q.size() > 0) ? exp_fault_q.pop_front() : -1;
                check({tag, " short_amount"}, short_amount, es);
                check({tag, " fault"}, fault, ef);
                check({tag, " coins left"}, exp_coin_q.size(), 0);
            end else if (coin_valid) begin
                valid_cyc++;
                if (seen == 0) begin
                    cur = (exp_coin_q.size() > 0) ? exp_coin_q.pop_front() : 0;
                end
                check({tag, " coin_value"}, coin_value, cur);
                seen++;
                if (ack_en && seen == 2) coin_ack = 1'b1;
            end else begin
                seen = 0;
            end
        end
        check({tag, " finished"}, fin, 1);
    endtask

    initial begin
        int dc, vc, w;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_amount = '0;
        refill     = 1'b0;
        coin_ack   = 1'b0;

        do_reset();
        check("reset req_ready", req_ready, 1);
        check("reset coin_valid", coin_valid, 0);
        check("reset done", done, 0);
        check("reset fault", fault, 0);
        check("reset short", short_amount, 0);
        check("reset coin_value", coin_value, 0);
        check("reset inv_empty", inv_empty, 0);

        // Test 1: 36 -> 10,10,10,5,1 with full-speed acks.
        exp_coin_q.push_back(10);
        exp_coin_q.push_back(10);
        exp_coin_q.push_back(10);
        exp_coin_q.push_back(5);
        exp_coin_q.push_back(1);
        expect_result(0, 0);
        send_req(6'd36, "t1");
        serve("t1", 1'b1, dc, vc);
        check("t1 done latency", dc, 17);
        check("t1 valid cycles", vc, 10);

        // Test 2: zero amount finishes with no coins.
        expect_result(0, 0);
        send_req(6'd0, "t2");
        serve("t2", 1'b1, dc, vc);
        check("t2 done latency", dc, 2);
        check("t2 valid cycles", vc, 0);

        // Test 3: fresh stock, 63 then 4 runs the 1-coins dry.
        do_reset();
        exp_coin_q.push_back(50);
        exp_coin_q.push_back(10);
        exp_coin_q.push_back(1);
        exp_coin_q.push_back(1);
        exp_coin_q.push_back(1);
        expect_result(0, 0);
        send_req(6'd63, "t3a");
        serve("t3a", 1'b1, dc, vc);
        exp_coin_q.push_back(1);
        expect_result(3, 0);
        send_req(6'd4, "t3b");
        serve("t3b", 1'b1, dc, vc);
        check("t3b inv_empty", inv_empty, 4'b0001);
        @(negedge clk);
        check("t3b idle req_ready", req_ready, 1);
        check("t3b short held", short_amount, 3);
        check("t3b fault cleared", fault, 0);

        // Test 4: refill in IDLE restores the 1-coins.
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        check("t4 inv_empty after refill", inv_empty, 4'b0000);
        exp_coin_q.push_back(1);
        exp_coin_q.push_back(1);
        exp_coin_q.push_back(1);
        exp_coin_q.push_back(1);
        expect_result(0, 0);
        send_req(6'd4, "t4");
        serve("t4", 1'b1, dc, vc);
        check("t4 inv_empty", inv_empty, 4'b0000);

        // Test 5: ack withheld -> timeout abort; the 10-coin stock stays at 4.
        do_reset();
        exp_coin_q.push_back(10);
        expect_result(10, 1);
        send_req(6'd10, "t5");
        serve("t5", 1'b0, dc, vc);
        check("t5 valid cycles", vc, 16);
        check("t5 done latency", dc, 18);
        @(negedge clk);
        check("t5 fault one pulse", fault, 0);
        check("t5 coin_valid idle", coin_valid, 0);
        exp_coin_q.push_back(10);
        exp_coin_q.push_back(10);
        exp_coin_q.push_back(10);
        exp_coin_q.push_back(10);
        expect_result(0, 0);
        send_req(6'd40, "t5b");
        serve("t5b", 1'b1, dc, vc);
        check("t5b inv_empty", inv_empty, 4'b0100);

        // Test 6: reset while a coin is pending drops it at once.
        do_reset();
        send_req(6'd36, "t6");
        w = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            w++;
        end while (!coin_valid && w < 20);
        check("t6 coin_valid seen", coin_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6 coin_valid after rst", coin_valid, 0);
        check("t6 req_ready after rst", req_ready, 1);
        rst = 1'b0;
        clear_scoreboard();
        exp_coin_q.push_back(5);
        expect_result(0, 0);
        send_req(6'd5, "t6b");
        serve("t6b", 1'b1, dc, vc);
        check("t6b valid cycles", vc, 2);
        check("t6b inv_empty", inv_empty, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
